// File: rtl/axilite_gen_pkg.sv
// axilite_gen_pkg: shared types for the AXI-Lite traffic generator.
// Holds the sequencer state enum, the OKAY response code and the error-count width.
package axilite_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_RD_REQ,
    ST_RD_RESP,
    ST_DONE
  } gen_state_e;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  localparam int ERR_W = 16;

  // Error counter sticks at all-ones instead of wrapping.
  function automatic logic [ERR_W-1:0] sat_inc(
    input logic [ERR_W-1:0] v
  );
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/axilite_gen_pattern.sv
// axilite_gen_pattern: per-beat address and data pattern.
// Ports: base_i/seed_i/beat_i in; addr_o = base + beat*stride, data_o = seed + beat.
module axilite_gen_pattern
  import axilite_gen_pkg::*;
#(
  parameter int ADDR_WIDTH  = 64,
  parameter int DATA_WIDTH  = 64,
  parameter int CNT_WIDTH   = 12,
  parameter int ADDR_STRIDE = 8
) (
  input  logic [ADDR_WIDTH-1:0] base_i,
  input  logic [DATA_WIDTH-1:0] seed_i,
  input  logic [CNT_WIDTH-1:0]  beat_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  localparam logic [ADDR_WIDTH-1:0] STRIDE =
    ADDR_WIDTH'(ADDR_STRIDE);

  // Both sums wrap naturally at the port width.
  assign addr_o = base_i
                + ADDR_WIDTH'(beat_i) * STRIDE;

  assign data_o = seed_i
                + DATA_WIDTH'(beat_i);

endmodule

// File: rtl/axilite_traffic_gen.sv
// axilite_traffic_gen: AXI-Lite master that writes num_beats words, then
// optionally reads them back and counts response/data errors.
// Ports: clk, rst (sync, active-high); start/num_beats/base_addr/seed run
// control; busy/done/err_count/beat_idx status; m_axi_* AW/W/B/AR/R master.
// Macro AXILITE_TRAFFIC_GEN_READBACK_EN enables the read-back phase;
// without it the run ends after the last B and the AR/R side is tied off.
module axilite_traffic_gen
  import axilite_gen_pkg::*;
#(
  parameter int ADDR_WIDTH  = 64,
  parameter int DATA_WIDTH  = 64,
  parameter int CNT_WIDTH   = 12,
  parameter int ADDR_STRIDE = 8
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic                    start,
  input  logic [CNT_WIDTH-1:0]    num_beats,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic [DATA_WIDTH-1:0]   seed,

  output logic                    busy,
  output logic                    done,
  output logic [ERR_W-1:0]        err_count,
  output logic [CNT_WIDTH-1:0]    beat_idx,

  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,

  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,

  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);

  gen_state_e state_q, state_d;

  logic [CNT_WIDTH-1:0]  beat_q, beat_d;
  logic [CNT_WIDTH-1:0]  nb_q, nb_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [DATA_WIDTH-1:0] seed_q, seed_d;
  logic [ERR_W-1:0]      err_q, err_d;

  // AW and W pending flags; each clears on its own handshake.
  logic awp_q, awp_d;
  logic wp_q, wp_d;

  logic [ADDR_WIDTH-1:0] pat_addr;
  logic [DATA_WIDTH-1:0] pat_data;
  logic                  last;

  // One pattern instance serves the write payload and the read check.
  axilite_gen_pattern #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .DATA_WIDTH  (DATA_WIDTH),
    .CNT_WIDTH   (CNT_WIDTH),
    .ADDR_STRIDE (ADDR_STRIDE)
  ) u_pattern (
    .base_i (base_q),
    .seed_i (seed_q),
    .beat_i (beat_q),
    .addr_o (pat_addr),
    .data_o (pat_data)
  );

  assign last = (beat_q == nb_q - CNT_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      nb_q    <= '0;
      base_q  <= '0;
      seed_q  <= '0;
      err_q   <= '0;
      awp_q   <= 1'b0;
      wp_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      nb_q    <= nb_d;
      base_q  <= base_d;
      seed_q  <= seed_d;
      err_q   <= err_d;
      awp_q   <= awp_d;
      wp_q    <= wp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    nb_d    = nb_q;
    base_d  = base_q;
    seed_d  = seed_q;
    err_d   = err_q;
    awp_d   = awp_q;
    wp_d    = wp_q;

    unique case (state_q)
      ST_IDLE,
      ST_DONE: begin
        if (start) begin
          nb_d   = num_beats;
          base_d = base_addr;
          seed_d = seed;
          beat_d = '0;
          err_d  = '0;
          if (num_beats == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_WR_REQ;
            awp_d   = 1'b1;
            wp_d    = 1'b1;
          end
        end
      end

      ST_WR_REQ: begin
        awp_d = awp_q & ~m_axi_awready;
        wp_d  = wp_q & ~m_axi_wready;
        if (!awp_d && !wp_d) begin
          state_d = ST_WR_RESP;
        end
      end

      ST_WR_RESP: begin
        if (m_axi_bvalid) begin
          if (m_axi_bresp != RESP_OKAY) begin
            err_d = sat_inc(err_q);
          end
          if (last) begin
            beat_d = '0;
`ifdef AXILITE_TRAFFIC_GEN_READBACK_EN
            state_d = ST_RD_REQ;
`else
            state_d = ST_DONE;
`endif
          end else begin
            beat_d  = beat_q + CNT_WIDTH'(1);
            state_d = ST_WR_REQ;
            awp_d   = 1'b1;
            wp_d    = 1'b1;
          end
        end
      end

`ifdef AXILITE_TRAFFIC_GEN_READBACK_EN
      ST_RD_REQ: begin
        if (m_axi_arready) begin
          state_d = ST_RD_RESP;
        end
      end

      ST_RD_RESP: begin
        if (m_axi_rvalid) begin
          // A bad response and bad data on one beat count once.
          if (m_axi_rresp != RESP_OKAY ||
              m_axi_rdata != pat_data) begin
            err_d = sat_inc(err_q);
          end
          if (last) begin
            beat_d  = '0;
            state_d = ST_DONE;
          end else begin
            beat_d  = beat_q + CNT_WIDTH'(1);
            state_d = ST_RD_REQ;
          end
        end
      end
`endif

      default: begin
        state_d = ST_IDLE;
        awp_d   = 1'b0;
        wp_d    = 1'b0;
      end
    endcase
  end

  assign busy = (state_q != ST_IDLE) &&
                (state_q != ST_DONE);
  assign done = (state_q == ST_DONE);

  assign err_count = err_q;
  assign beat_idx  = beat_q;

  assign m_axi_awaddr  = pat_addr;
  assign m_axi_awvalid = awp_q;
  assign m_axi_wdata   = pat_data;
  assign m_axi_wstrb   = '1;
  assign m_axi_wvalid  = wp_q;
  assign m_axi_bready  = (state_q == ST_WR_RESP);

`ifdef AXILITE_TRAFFIC_GEN_READBACK_EN
  assign m_axi_araddr  = pat_addr;
  assign m_axi_arvalid = (state_q == ST_RD_REQ);
  assign m_axi_rready  = (state_q == ST_RD_RESP);
`else
  assign m_axi_araddr  = '0;
  assign m_axi_arvalid = 1'b0;
  assign m_axi_rready  = 1'b0;

  logic unused_rd;
  assign unused_rd = ^{m_axi_arready,
                       m_axi_rvalid,
                       m_axi_rresp,
                       m_axi_rdata};
`endif

endmodule

// File: tb/tb_axilite_traffic_gen.sv
// tb_axilite_traffic_gen: random-delay AXI-Lite slave plus reference model
// for axilite_traffic_gen; reports "<passed>/<total> checks passed".
module tb_axilite_traffic_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [11:0] num_beats;
  logic [63:0] base_addr;
  logic [63:0] seed;
  logic        busy;
  logic        done;
  logic [15:0] err_count;
  logic [11:0] beat_idx;
  logic [63:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [63:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  always #5 clk = ~clk;

  axilite_traffic_gen dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .num_beats     (num_beats),
    .base_addr     (base_addr),
    .seed          (seed),
    .busy          (busy),
    .done          (done),
    .err_count     (err_count),
    .beat_idx      (beat_idx),
    .m_axi_awaddr  (awaddr),
    .m_axi_awvalid (awvalid),
    .m_axi_awready (awready),
    .m_axi_wdata   (wdata),
    .m_axi_wstrb   (wstrb),
    .m_axi_wvalid  (wvalid),
    .m_axi_wready  (wready),
    .m_axi_bresp   (bresp),
    .m_axi_bvalid  (bvalid),
    .m_axi_bready  (bready),
    .m_axi_araddr  (araddr),
    .m_axi_arvalid (arvalid),
    .m_axi_arready (arready),
    .m_axi_rdata   (rdata),
    .m_axi_rresp   (rresp),
    .m_axi_rvalid  (rvalid),
    .m_axi_rready  (rready)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h",
                  tag, got, exp);
  endtask

  // slave configuration
  int rnd, wd0, bad_b, bad_rd, bad_rr, stall_b;
  bit clr = 1'b0;

  // slave / monitor state
  logic [63:0] aw_q[$];
  logic [63:0] w_q[$];
  logic [63:0] ar_q[$];
  logic [63:0] mem [logic [63:0]];
  int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  int viol, split, brise, cyc, aw0_cyc;
  bit ar_seen, any_valid;
  bit aw_f, w_f, b_f, ar_f, r_f;
  logic p_awv, p_wv, p_arv, p_brd;
  logic [63:0] p_awa, p_wd, p_ara;

  initial begin
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst || clr) begin
        awready = 0; wready = 0; arready = 0;
        bvalid = 0; bresp = 0;
        rvalid = 0; rresp = 0; rdata = 0;
        aw_f = 0; w_f = 0; b_f = 0;
        ar_f = 0; r_f = 0;
        p_awv = 0; p_wv = 0; p_arv = 0; p_brd = 0;
        if (clr) begin
          aw_q.delete(); w_q.delete();
          ar_q.delete(); mem.delete();
          aw_cnt = 0; w_cnt = 0; b_cnt = 0;
          ar_cnt = 0; r_cnt = 0;
          viol = 0; split = 0; brise = 0;
          ar_seen = 0; any_valid = 0;
          clr = 0;
        end
      end else begin
        // protocol rules on what the master drives now
        if (awvalid && aw_cnt != b_cnt) viol++;
        if (wvalid && w_cnt != b_cnt) viol++;
        if (awvalid && beat_idx != 12'(aw_cnt)) viol++;
        if (wvalid && wstrb != 8'hFF) viol++;
        if (p_awv && !aw_f &&
            (!awvalid || awaddr != p_awa)) viol++;
        if (p_wv && !w_f &&
            (!wvalid || wdata != p_wd)) viol++;
        if (p_arv && !ar_f &&
            (!arvalid || araddr != p_ara)) viol++;
        if (bready && !(aw_cnt == b_cnt + 1 &&
                        w_cnt == b_cnt + 1)) viol++;
        if (arvalid && (ar_cnt != r_cnt ||
                        b_cnt != aw_cnt)) viol++;
        if (rready && ar_cnt != r_cnt + 1) viol++;
        if (!busy && (awvalid || wvalid || bready ||
                      arvalid || rready)) viol++;
        if (!awvalid && wvalid) split++;
        if (bready && !p_brd) brise++;
        if (arvalid) ar_seen = 1;
        if (awvalid || wvalid || arvalid ||
            bready || rready) any_valid = 1;
        p_awv = awvalid; p_awa = awaddr;
        p_wv = wvalid; p_wd = wdata;
        p_arv = arvalid; p_ara = araddr;
        p_brd = bready;

        if (b_f) bvalid = 0;
        if (r_f) rvalid = 0;

        if (!bvalid && aw_cnt > b_cnt &&
            w_cnt > b_cnt && b_cnt != stall_b &&
            (rnd == 0 || $urandom_range(0, 2) == 0)) begin
          bvalid = 1;
          bresp = (b_cnt == bad_b) ? 2'b10 : 2'b00;
          mem[aw_q[b_cnt]] = w_q[b_cnt];
        end
        b_f = bvalid && bready;
        if (b_f) b_cnt++;

        awready = (rnd == 0) ? 1'b1
                : 1'($urandom_range(0, 1));
        wready = (rnd == 0) ? 1'b1
               : 1'($urandom_range(0, 1));
        if (wd0 != 0 && w_cnt == 0)
          wready = (aw_cnt > 0 && cyc >= aw0_cyc + 3);
        aw_f = awvalid && awready;
        if (aw_f) begin
          if (aw_cnt == 0) aw0_cyc = cyc;
          aw_q.push_back(awaddr);
          aw_cnt++;
        end
        w_f = wvalid && wready;
        if (w_f) begin
          w_q.push_back(wdata);
          w_cnt++;
        end

        if (!rvalid && ar_cnt > r_cnt &&
            (rnd == 0 || $urandom_range(0, 2) == 0)) begin
          rvalid = 1;
          if (r_cnt == bad_rd) rdata = 64'hDEAD;
          else if (mem.exists(ar_q[r_cnt]))
            rdata = mem[ar_q[r_cnt]];
          else rdata = 64'h0;
          rresp = (r_cnt == bad_rr) ? 2'b10 : 2'b00;
        end
        r_f = rvalid && rready;
        if (r_f) r_cnt++;

        arready = (rnd == 0) ? 1'b1
                : 1'($urandom_range(0, 1));
        ar_f = arvalid && arready;
        if (ar_f) begin
          ar_q.push_back(araddr);
          ar_cnt++;
        end
      end
    end
  end

  task automatic launch(input int nb,
                        input logic [63:0] b,
                        input logic [63:0] s,
                        input int rn, input int wd,
                        input int bb, input int brd,
                        input int brr, input int sb);
    rnd = rn; wd0 = wd; bad_b = bb;
    bad_rd = brd; bad_rr = brr; stall_b = sb;
    clr = 1;
    repeat (2) @(negedge clk);
    num_beats = 12'(nb);
    base_addr = b;
    seed = s;
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic run(input string nm, input int nb,
                     input logic [63:0] b,
                     input logic [63:0] s,
                     input int rn, input int wd,
                     input int bb, input int brd,
                     input int brr);
    int cy;
    int e;
    int n;
    launch(nb, b, s, rn, wd, bb, brd, brr, -1);
    cy = 1;
    while (!done && cy < 3000) begin
      // a start while busy must not disturb the run
      start = (cy == 3 && busy);
      if (start) begin
        num_beats = num_beats + 12'd5;
        base_addr = ~base_addr;
      end
      @(negedge clk);
      cy++;
    end
    start = 0;
    #1;
    chk({nm, ".done"}, 64'(done), 64'd1);
    chk({nm, ".busy"}, 64'(busy), 64'd0);
    chk({nm, ".aw_n"}, 64'(aw_q.size()), 64'(nb));
    chk({nm, ".w_n"}, 64'(w_q.size()), 64'(nb));
    chk({nm, ".b_n"}, 64'(b_cnt), 64'(nb));
    chk({nm, ".bphase"}, 64'(brise), 64'(nb));
    n = (aw_q.size() < nb) ? aw_q.size() : nb;
    for (int i = 0; i < n; i++)
      chk($sformatf("%s.awaddr%0d", nm, i),
          aw_q[i], b + 64'(i) * 64'd8);
    n = (w_q.size() < nb) ? w_q.size() : nb;
    for (int i = 0; i < n; i++)
      chk($sformatf("%s.wdata%0d", nm, i),
          w_q[i], s + 64'(i));
    e = (bb >= 0 && bb < nb) ? 1 : 0;
`ifdef AXILITE_TRAFFIC_GEN_READBACK_EN
    chk({nm, ".ar_n"}, 64'(ar_q.size()), 64'(nb));
    chk({nm, ".r_n"}, 64'(r_cnt), 64'(nb));
    n = (ar_q.size() < nb) ? ar_q.size() : nb;
    for (int i = 0; i < n; i++)
      chk($sformatf("%s.araddr%0d", nm, i),
          ar_q[i], b + 64'(i) * 64'd8);
    for (int i = 0; i < nb; i++)
      if (i == brr ||
          (i == brd && 64'hDEAD != s + 64'(i))) e++;
`else
    chk({nm, ".ar_seen"}, 64'(ar_seen), 64'd0);
`endif
    chk({nm, ".err"}, 64'(err_count), 64'(e));
    chk({nm, ".proto"}, 64'(viol), 64'd0);
    if (wd != 0) chk({nm, ".split"}, 64'(split), 64'd3);
    if (nb == 0) begin
      chk({nm, ".lat"}, 64'(cy), 64'd1);
      chk({nm, ".novalid"}, 64'(any_valid), 64'd0);
    end
  endtask

  task automatic chk_rst(input string nm);
    chk({nm, ".ctl"},
        64'({busy, done, awvalid, wvalid,
             bready, arvalid, rready}), 64'd0);
    chk({nm, ".err"}, 64'(err_count), 64'd0);
    chk({nm, ".beat"}, 64'(beat_idx), 64'd0);
    chk({nm, ".awaddr"}, awaddr, 64'd0);
    chk({nm, ".araddr"}, araddr, 64'd0);
    chk({nm, ".wdata"}, wdata, 64'd0);
    chk({nm, ".wstrb"}, 64'(wstrb), 64'hFF);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    int k;
    rst = 1; start = 0; num_beats = 0;
    base_addr = 0; seed = 0;
    rnd = 0; wd0 = 0; bad_b = -1;
    bad_rd = -1; bad_rr = -1; stall_b = -1;
    repeat (3) @(negedge clk);
    #1;
    chk_rst("por");
    rst = 0;

    run("basic", 4, 64'h8000_0000, 64'h10,
        0, 0, -1, -1, -1);
    run("wdly", 3, 64'h1000, 64'h55,
        0, 1, -1, -1, -1);
    run("errs", 4, 64'h8000_0000, 64'h10,
        0, 0, 1, 2, -1);
    run("both", 3, 64'h40, 64'h7,
        1, 0, -1, 1, 1);
    run("zero", 0, 64'h2000, 64'h1,
        0, 0, -1, -1, -1);
    run("wrap", 3, 64'hFFFF_FFFF_FFFF_FFF0,
        64'hFFFF_FFFF_FFFF_FFFE, 1, 0, -1, -1, -1);

    launch(3, 64'hA000, 64'h33, 0, 0,
           -1, -1, -1, 1);
    k = 0;
    while (k < 200) begin
      @(negedge clk);
      #1;
      if (bready && b_cnt == 1) break;
      k++;
    end
    chk("mid.reach", 64'(bready && b_cnt == 1), 64'd1);
    rst = 1;
    @(negedge clk);
    #1;
    chk_rst("mid");
    rst = 0;
    run("after", 1, 64'hB000, 64'h99,
        0, 0, -1, -1, -1);
    run("two", 2, 64'hC000, 64'h5,
        1, 0, -1, -1, -1);

    for (int r = 0; r < 8; r++) begin
      nb = $urandom_range(1, 6);
      run($sformatf("rnd%0d", r), nb,
          {$urandom(), $urandom()},
          {$urandom(), $urandom()},
          1, 0,
          int'($urandom_range(0, nb)) - 1,
          int'($urandom_range(0, nb)) - 1,
          int'($urandom_range(0, nb)) - 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/axilite_traffic_gen.md
AXILITE_TRAFFIC_GEN -- requirements
Module: axilite_traffic_gen

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, 64, AXI-Lite address width.
REQ-002 SHALL have parameter DATA_WIDTH, 64, AXI-Lite data width, a multiple of 8.
REQ-003 SHALL have parameter CNT_WIDTH, 12, width of the beat counter (max 2^CNT_WIDTH-1 beats).
REQ-004 SHALL have parameter ADDR_STRIDE, 8, byte increment between successive beats.
REQ-005 SHALL have ports: clk in 1 clock; rst in 1 reset, synchronous, active-high.
REQ-006 SHALL have ports: start in 1 run request; num_beats in CNT_WIDTH beats per run; base_addr in ADDR_WIDTH first address; seed in DATA_WIDTH pattern seed.
REQ-007 SHALL have ports: busy out 1; done out 1; err_count out 16 saturating error count; beat_idx out CNT_WIDTH current beat.
REQ-008 SHALL have AW/W ports: m_axi_awaddr out ADDR_WIDTH; awvalid out 1; awready in 1; wdata out DATA_WIDTH; wstrb out DATA_WIDTH/8; wvalid out 1; wready in 1.
REQ-009 SHALL have B/AR/R ports: bresp in 2; bvalid in 1; bready out 1; araddr out ADDR_WIDTH; arvalid out 1; arready in 1; rdata in DATA_WIDTH; rresp in 2; rvalid in 1; rready out 1.

Function
REQ-010 SHALL sequence states IDLE -> WR_REQ -> WR_RESP -> (next beat or RD_REQ) -> RD_RESP -> (next beat or DONE).
REQ-011 SHALL leave IDLE or DONE on start=1, latching num_beats, base_addr and seed, and clearing beat_idx and err_count.
REQ-012 SHALL ignore start while busy.
REQ-013 SHALL go directly from IDLE to DONE, with no bus activity, when num_beats=0.
REQ-014 SHALL drive awaddr/araddr = base_addr + beat_idx*ADDR_STRIDE, truncated modulo 2^ADDR_WIDTH.
REQ-015 SHALL drive wdata = seed + beat_idx (zero-extended, modulo 2^DATA_WIDTH) and wstrb all ones.
REQ-016 SHALL assert awvalid and wvalid together on entry to WR_REQ, and drop each independently on its own handshake; AW and W accepted in the same or different cycles are both legal.
REQ-017 SHALL hold payloads stable while the matching valid is high and not yet accepted.
REQ-018 SHALL enter WR_RESP only once both AW and W have been accepted, and assert bready only in WR_RESP.
REQ-019 SHALL increment err_count when bresp != 2'b00 at the B handshake.
REQ-020 SHALL advance beat_idx after B; after the last beat it SHALL clear beat_idx and go to RD_REQ.
REQ-021 SHALL assert arvalid in RD_REQ until arready, then go to RD_RESP with rready=1.
REQ-022 SHALL increment err_count at the R handshake if rresp != 0 or rdata != the expected wdata for that beat; a beat with both faults counts once.
REQ-023 SHALL saturate err_count at 16'hFFFF.
REQ-024 SHALL hold done=1 and busy=0 in DONE; busy=1 in every state except IDLE and DONE.
REQ-025 SHALL keep exactly one transaction outstanding per channel pair; never more than one AW or AR unacknowledged.

Reset
REQ-026 SHALL on rst force state IDLE and drive all valids, bready, rready, done, busy = 0; err_count, beat_idx, awaddr, araddr, wdata = 0; wstrb all ones.
REQ-027 SHALL on rst mid-transaction abandon the transfer without waiting for pending responses.

Configuration
REQ-028 SHALL use macro AXILITE_TRAFFIC_GEN_READBACK_EN.
REQ-029 SHALL, when AXILITE_TRAFFIC_GEN_READBACK_EN is defined, perform the read phase of REQ-020..REQ-022.
REQ-030 SHALL, when AXILITE_TRAFFIC_GEN_READBACK_EN is undefined, go from the last B directly to DONE, tie arvalid=0, rready=0, araddr=0, and count only bresp errors.

Structure
REQ-031 SHALL take the state enum, RESP_OKAY=2'b00 and the err_count width from shared package axilite_gen_pkg.
REQ-032 SHALL contain one sub-module, axilite_gen_pattern, computing address and expected data from base, seed and beat_idx; it is shared by the write and read paths.

Verification
REQ-033 SHALL cover: num_beats=4, base 0x8000_0000, seed 0x10, always-ready slave -> AW at 0x8000_0000..0x8000_0018, wdata 0x10..0x13, four reads matching, err_count=0, done=1.
REQ-034 SHALL cover: wready delayed 3 cycles after awready on beat 0 -> awvalid drops after its handshake, wvalid stays high with stable wdata, single bready phase follows.
REQ-035 SHALL cover: slave returns rdata 0xDEAD on beat 2 and bresp=2'b10 on beat 1 -> err_count=2 at done.
REQ-036 SHALL cover: num_beats=0 -> done next cycle, no valid ever asserted.
REQ-037 SHALL cover: rst asserted in WR_RESP of beat 1 -> all outputs at reset values the next cycle; a new start with num_beats=1 completes cleanly.
REQ-038 SHALL cover: build without AXILITE_TRAFFIC_GEN_READBACK_EN, num_beats=2 -> arvalid never asserted, done after the second B.
